pattern_player: RTL

//  Plays one Simon Says round: walks the pattern ROM (mem) from address 0 up to

---
 rtl/pattern_player.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pattern_player.sv
// Plays one Simon Says round by walking the pattern ROM from address 0 to round_len-1.
// Each step lights the fetched pattern for ON_TICKS cycles, then blanks the LEDs for OFF_TICKS cycles.
module pattern_player #(
    parameter int ADDR_W    = 8,
    parameter int BTN_W     = 12,
    parameter int ON_TICKS  = 1000,
    parameter int OFF_TICKS = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] round_len,
    output logic [ADDR_W-1:0] sel,
    output logic              en,
    input  logic [BTN_W-1:0]  btns_in,
    output logic [BTN_W-1:0]  leds,
    output logic              busy,
    output logic              done
);

    // Handshake: a round request is a single-cycle start pulse, accepted only in IDLE.
    // busy covers the accepted round, and done pulses for one cycle when it ends.
    // done and busy are never high in the same cycle.
    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_TICKS - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHOW,
        S_GAP,
        S_FIN
    } state_t;

    state_t              state, state_d;
    logic [TIMER_W-1:0]  timer, timer_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   sel_d;
    logic [BTN_W-1:0]    leds_d;
    logic                en_d, busy_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            timer <= '0;
            len_q <= '0;
            sel   <= '0;
            en    <= 1'b0;
            leds  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            timer <= timer_d;
            len_q <= len_d;
            sel   <= sel_d;
            en    <= en_d;
            leds  <= leds_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Every output is registered, so each value below is what the pin shows next cycle.
    always_comb begin
        state_d = state;
        timer_d = timer;
        len_d   = len_q;
        sel_d   = sel;
        leds_d  = leds;
        busy_d  = busy;
        en_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (round_len != '0) begin
                        len_d   = round_len;
                        sel_d   = '0;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                leds_d  = btns_in;
                timer_d = ON_LOAD;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (timer == '0) begin
                    leds_d  = '0;
                    timer_d = OFF_LOAD;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            S_GAP: begin
                if (timer != '0) begin
                    timer_d = timer - 1'b1;
                end else if (sel == len_q - ADDR_W'(1)) begin
                    // busy drops as done rises so the two never overlap
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else begin
                    sel_d   = sel + ADDR_W'(1);
                    en_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule
